// File: rtl/starbug_regfile_pkg.sv
// Shared constants and helpers for the starbug dual-lane register file.
// Optional same-cycle write-to-read forwarding is built with STARBUG_REGFILE_BYPASS_EN.
package starbug_regfile_pkg;
    localparam int NUMREGS_E       = 16;
    localparam int NUMREGS_I       = 32;
    localparam int STARBUG_LANES   = 2;
    localparam int STARBUG_RDPORTS = 2 * STARBUG_LANES;
    localparam int REGAW           = 5;

    // A register exists only if it is nonzero and inside the configured file.
    function automatic logic reg_ok(input logic [REGAW-1:0] a, input int numregs);
        return (a != '0) && (int'(a) < numregs);
    endfunction
endpackage

// File: rtl/starbug_rdport.sv
// One combinational read port: decode, x0 / out-of-range masking and optional forwarding.
// Forwarding is present only when STARBUG_REGFILE_BYPASS_EN is defined.
module starbug_rdport
    import starbug_regfile_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int NUMREGS = NUMREGS_I
) (
    input  logic [REGAW-1:0]                       a,
    input  logic [NUMREGS-1:0][XLEN-1:0]           regs,
    input  logic [STARBUG_LANES-1:0]               we,
    input  logic [STARBUG_LANES-1:0][REGAW-1:0]    wa,
    input  logic [STARBUG_LANES-1:0][XLEN-1:0]     wd,
    output logic [XLEN-1:0]                        rd
);
    localparam int AW = $clog2(NUMREGS);

    logic ok;
    assign ok = reg_ok(a, NUMREGS);

`ifdef STARBUG_REGFILE_BYPASS_EN
    // Later lanes are later in program order, so they override earlier ones.
    always_comb begin
        rd = ok ? regs[a[AW-1:0]] : '0;
        for (int l = 0; l < STARBUG_LANES; l++)
            if (ok && we[l] && (wa[l] == a)) rd = wd[l];
    end
`else
    logic unused_byp;
    assign unused_byp = ^{we, wa, wd};
    assign rd = ok ? regs[a[AW-1:0]] : '0;
`endif
endmodule

// File: rtl/starbug_regfile.sv
// Dual-lane register file: 4 read ports, 2 write ports, collision / illegal-register pulses.
// Build with STARBUG_REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module starbug_regfile
    import starbug_regfile_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int E_SUPPORTED = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       a1_0,
    input  logic [4:0]       a2_0,
    output logic [XLEN-1:0]  rd1_0,
    output logic [XLEN-1:0]  rd2_0,
    input  logic             we3_0,
    input  logic [4:0]       a3_0,
    input  logic [XLEN-1:0]  wd3_0,
    input  logic [4:0]       a1_1,
    input  logic [4:0]       a2_1,
    output logic [XLEN-1:0]  rd1_1,
    output logic [XLEN-1:0]  rd2_1,
    input  logic             we3_1,
    input  logic [4:0]       a3_1,
    input  logic [XLEN-1:0]  wd3_1,
    output logic             WrCollisionW,
    output logic             IllegalRegW
);
    localparam int NUMREGS = (E_SUPPORTED != 0) ? NUMREGS_E : NUMREGS_I;

    logic [STARBUG_LANES-1:0]                we, wok, ill, byp_we;
    logic [STARBUG_LANES-1:0][REGAW-1:0]     wa;
    logic [STARBUG_LANES-1:0][XLEN-1:0]      wd;
    logic [NUMREGS-1:1][XLEN-1:0]            mem;
    logic [NUMREGS-1:0][XLEN-1:0]            regs;
    logic [STARBUG_RDPORTS-1:0][REGAW-1:0]   ra;
    logic [STARBUG_RDPORTS-1:0][XLEN-1:0]    rdv;
    logic                                    col_n, ill_n;

    assign we = {we3_1, we3_0};
    assign wa = {a3_1, a3_0};
    assign wd = {wd3_1, wd3_0};

    for (genvar l = 0; l < STARBUG_LANES; l++) begin : g_lane
        assign wok[l] = we[l] & reg_ok(wa[l], NUMREGS);
        assign ill[l] = we[l] & (int'(wa[l]) >= NUMREGS);
    end

    // A write that reset will discard must not be forwarded either.
    assign byp_we = wok & {STARBUG_LANES{reset}};

    // Lane loop runs in program order; the last matching NBA (lane 1) wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem <= '0;
        end else begin
            for (int r = 1; r < NUMREGS; r++)
                for (int l = 0; l < STARBUG_LANES; l++)
                    if (wok[l] && (int'(wa[l]) == r)) mem[r] <= wd[l];
        end
    end

    assign col_n = wok[0] & wok[1] & (wa[0] == wa[1]);
    assign ill_n = |ill;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            WrCollisionW <= 1'b0;
            IllegalRegW  <= 1'b0;
        end else begin
            WrCollisionW <= col_n;
            IllegalRegW  <= ill_n;
        end
    end

    assign regs = {mem, {XLEN{1'b0}}};
    assign ra   = {a2_1, a1_1, a2_0, a1_0};

    for (genvar p = 0; p < STARBUG_RDPORTS; p++) begin : g_rd
        starbug_rdport #(.XLEN(XLEN), .NUMREGS(NUMREGS)) u_rdport (
            .a    (ra[p]),
            .regs (regs),
            .we   (byp_we),
            .wa   (wa),
            .wd   (wd),
            .rd   (rdv[p])
        );
    end

    assign rd1_0 = rdv[0];
    assign rd2_0 = rdv[1];
    assign rd1_1 = rdv[2];
    assign rd2_1 = rdv[3];
endmodule
